dht11_bcd_conv: RTL and testbench

DHT11_BCD_CONV -- requirements
Module: dht11_bcd_conv

---
 rtl/dht11_bcd_conv_if.sv | 25 ++
 rtl/dht11_bcd_conv.sv | 112 +++++++++++
 tb/tb_dht11_bcd_conv.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dht11_bcd_conv_if.sv
// Bundle of DHT11 driver inputs and BCD result outputs for dht11_bcd_conv.
// The driver side uses the master modport and the converter uses the slave modport.
interface dht11_bcd_conv_if #(
  parameter int BYTE_SZ  = 8,
  parameter int VALUE_SZ = 2 * BYTE_SZ
);
  logic [VALUE_SZ-1:0] I_VALUE;
  logic                I_CONV;
  logic                I_ERR;
  logic [11:0]         O_HUM_BCD;
  logic [11:0]         O_TEMP_BCD;
  logic                O_VALID;
  logic                O_BUSY;
  logic                O_ERR;

  modport master (
    output I_VALUE, I_CONV, I_ERR,
    input  O_HUM_BCD, O_TEMP_BCD, O_VALID, O_BUSY, O_ERR
  );

  modport slave (
    input  I_VALUE, I_CONV, I_ERR,
    output O_HUM_BCD, O_TEMP_BCD, O_VALID, O_BUSY, O_ERR
  );
endinterface

// File: rtl/dht11_bcd_conv.sv
// Converts DHT11 humidity/temperature bytes to 3-digit BCD.
// Both bytes run through double-dabble in parallel, one bit per clock.
module dht11_bcd_conv #(
  parameter int BYTE_SZ  = 8,
  parameter int VALUE_SZ = 2 * BYTE_SZ
) (
  input  logic             CLK,
  input  logic             RST,
  dht11_bcd_conv_if.slave  bus
);
  localparam int CNT_W = $clog2(BYTE_SZ + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0][11:0]          bcd_q, bcd_d, bcd_step;
  logic [1:0][BYTE_SZ-1:0]   bin_q, bin_d, bin_step, bin_load;
  logic [11:0]               hum_q, hum_d, temp_q, temp_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  // Channel 1 is humidity (upper byte), channel 0 is temperature (lower byte).
  assign bin_load[1] = bus.I_VALUE[VALUE_SZ-1 -: BYTE_SZ];
  assign bin_load[0] = bus.I_VALUE[BYTE_SZ-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dabble
      logic [10:0] adj;
      // The hundreds digit's top bit is shifted out, so only its low 3 bits are kept.
      always_comb begin
        for (int d = 0; d < 2; d++) begin
          adj[4*d +: 4] = (bcd_q[gi][4*d +: 4] >= 4'd5) ? bcd_q[gi][4*d +: 4] + 4'd3
                                                         : bcd_q[gi][4*d +: 4];
        end
        adj[10:8] = bcd_q[gi][10:8] + ((bcd_q[gi][11:8] >= 4'd5) ? 3'd3 : 3'd0);
      end
      assign bcd_step[gi] = {adj, bin_q[gi][BYTE_SZ-1]};
      assign bin_step[gi] = {bin_q[gi][BYTE_SZ-2:0], 1'b0};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    hum_d   = hum_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.I_CONV) begin
          if (bus.I_ERR) begin
            err_d = 1'b1;
          end else begin
            bin_d   = bin_load;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_step;
        bin_d = bin_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BYTE_SZ - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hum_d   = bcd_q[1];
        temp_d  = bcd_q[0];
        valid_d = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      hum_q   <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      hum_q   <= hum_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.O_HUM_BCD  = hum_q;
  assign bus.O_TEMP_BCD = temp_q;
  assign bus.O_VALID    = valid_q;
  assign bus.O_BUSY     = (state_q != IDLE);
  assign bus.O_ERR      = err_q;
endmodule

// File: tb/tb_dht11_bcd_conv.sv
// Scoreboard bench for dht11_bcd_conv: stimulus queues expected BCD results
// with their due edge; a negedge monitor checks every O_VALID pulse.
module tb_dht11_bcd_conv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [11:0] hum;
    logic [11:0] temp;
    int          at_edge;
  } exp_t;

  exp_t sb[$];

  dht11_bcd_conv_if #(.BYTE_SZ(8), .VALUE_SZ(16)) bus ();

  dht11_bcd_conv #(.BYTE_SZ(8), .VALUE_SZ(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = 0x%0h (edge %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every O_VALID must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.O_VALID !== 1'b0) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got O_VALID=%b with empty scoreboard (edge %0d)",
                 bus.O_VALID, cyc);
      end else begin
        e = sb.pop_front();
        check("valid_hum", 32'(bus.O_HUM_BCD), 32'(e.hum));
        check("valid_temp", 32'(bus.O_TEMP_BCD), 32'(e.temp));
        check("valid_err", 32'(bus.O_ERR), 32'd0);
        check("valid_edge", 32'(cyc), 32'(e.at_edge));
      end
    end
  end

  // Called at a negedge; the strobe is sampled at the next posedge (edge k),
  // so the result is due at edge k+9 = current cyc + 10.
  task automatic pulse(input logic [15:0] v, input logic err, input logic accept,
                       input logic [11:0] eh, input logic [11:0] et);
    exp_t e;
    bus.I_VALUE = v;
    bus.I_ERR   = err;
    bus.I_CONV  = 1'b1;
    if (accept) begin
      e.hum     = eh;
      e.temp    = et;
      e.at_edge = cyc + 10;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.I_CONV = 1'b0;
    bus.I_ERR  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.I_VALUE = '0;
    bus.I_CONV  = 1'b0;
    bus.I_ERR   = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_hum", 32'(bus.O_HUM_BCD), 32'h000);
    check("rst_temp", 32'(bus.O_TEMP_BCD), 32'h000);
    check("rst_valid", 32'(bus.O_VALID), 32'd0);
    check("rst_busy", 32'(bus.O_BUSY), 32'd0);
    check("rst_err", 32'(bus.O_ERR), 32'd0);

    // Normal conversion with busy timing.
    pulse(16'h3719, 1'b0, 1'b1, 12'h055, 12'h025);
    check("busy_rise", 32'(bus.O_BUSY), 32'd1);
    idle(8);
    check("busy_k8", 32'(bus.O_BUSY), 32'd1);
    idle(1);
    check("busy_fall", 32'(bus.O_BUSY), 32'd0);
    idle(1);
    check("valid_one_cycle", 32'(bus.O_VALID), 32'd0);
    check("hold_hum", 32'(bus.O_HUM_BCD), 32'h055);
    drain();

    // Extremes and assorted values.
    pulse(16'hFF00, 1'b0, 1'b1, 12'h255, 12'h000); drain();
    pulse(16'h6432, 1'b0, 1'b1, 12'h100, 12'h050); drain();
    pulse(16'h6309, 1'b0, 1'b1, 12'h099, 12'h009); drain();
    pulse(16'hC87F, 1'b0, 1'b1, 12'h200, 12'h127); drain();

    // Error strobe: sticky until the next valid result.
    pulse(16'h3719, 1'b0, 1'b1, 12'h055, 12'h025); drain();
    pulse(16'hAAAA, 1'b1, 1'b0, 12'h000, 12'h000);
    check("err_set", 32'(bus.O_ERR), 32'd1);
    check("err_busy", 32'(bus.O_BUSY), 32'd0);
    check("err_hum_hold", 32'(bus.O_HUM_BCD), 32'h055);
    check("err_temp_hold", 32'(bus.O_TEMP_BCD), 32'h025);
    idle(3);
    check("err_sticky", 32'(bus.O_ERR), 32'd1);
    pulse(16'h0A05, 1'b0, 1'b1, 12'h010, 12'h005);
    idle(4);
    check("err_mid_conv", 32'(bus.O_ERR), 32'd1);
    drain();
    check("err_cleared", 32'(bus.O_ERR), 32'd0);

    // Strobes at k+3 and k+9 are dropped; k+10 restarts.
    pulse(16'h1234, 1'b0, 1'b1, 12'h018, 12'h052);
    idle(2);
    pulse(16'h5555, 1'b0, 1'b0, 12'h000, 12'h000);
    idle(5);
    pulse(16'h5555, 1'b0, 1'b0, 12'h000, 12'h000);
    pulse(16'h2A2A, 1'b0, 1'b1, 12'h042, 12'h042);
    drain();

    // Reset during SHIFT aborts the conversion.
    pulse(16'h3719, 1'b0, 1'b0, 12'h000, 12'h000);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hum", 32'(bus.O_HUM_BCD), 32'h000);
    check("midrst_temp", 32'(bus.O_TEMP_BCD), 32'h000);
    check("midrst_busy", 32'(bus.O_BUSY), 32'd0);
    idle(10);
    pulse(16'h3719, 1'b0, 1'b1, 12'h055, 12'h025); drain();

    // Reset and strobe at the same edge: no conversion starts.
    bus.I_VALUE = 16'h6432;
    bus.I_CONV  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.I_CONV = 1'b0;
    check("coll_busy", 32'(bus.O_BUSY), 32'd0);
    check("coll_hum", 32'(bus.O_HUM_BCD), 32'h000);
    idle(12);
    check("coll_busy_late", 32'(bus.O_BUSY), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
